spw_tx_fifo_bridge: RTL and testbench

SPW_TX_FIFO_BRIDGE -- requirements
Module: spw_tx_fifo_bridge

---
 rtl/spw_tx_fifo_bridge.sv | 139 +++++++++++++
 tb/tb_spw_tx_fifo_bridge.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spw_tx_fifo_bridge.sv
// Avalon-MM to SpaceWire codec transmit bridge.
// Software pushes 9-bit {flag, data} characters into a small FIFO. The head entry is
// presented to the codec, and one entry is popped on each edge where tx_write and
// tx_rdy are both high.
//
// Ports:
//   clk, reset_n       system clock, asynchronous active-low reset
//   address            register select: 0 data, 1 status/control, 2 irq enable, 3 sent count
//   chipselect,        Avalon-MM slave select and active-low write strobe
//   write_n
//   writedata,         Avalon-MM write data and zero-wait read data
//   readdata
//   tx_write           high while the FIFO holds an entry; tx_flag/tx_data carry the head
//   tx_flag, tx_data
//   tx_rdy             codec ready
//   irq                level interrupt: empty and/or sticky overflow, each gated by an enable
module spw_tx_fifo_bridge #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        tx_write,
  output logic        tx_flag,
  output logic [7:0]  tx_data,
  input  logic        tx_rdy,
  output logic        irq
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;
  logic [1:0]    r_en;
  logic [15:0]   r_sent;

  logic w_wr;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_req;
  logic w_push;
  logic w_flush;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic w_sent_clr;
  logic [8:0] w_head;

  assign w_wr       = chipselect & ~write_n;
  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(DEPTH));
  assign w_pop      = ~w_empty & tx_rdy;
  assign w_push_req = w_wr & (address == 2'd0);
  // A full FIFO still accepts a push when the codec drains an entry on the same edge.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_set  = w_push_req & w_full & ~w_pop;
  assign w_ovf_clr  = w_wr & (address == 2'd1) & writedata[0];
  assign w_flush    = w_wr & (address == 2'd1) & writedata[1];
  assign w_sent_clr = w_wr & (address == 2'd3);
  assign w_head     = r_mem[r_rptr];

  assign tx_write = ~w_empty;
  assign tx_flag  = w_head[8];
  assign tx_data  = w_head[7:0];
  assign irq      = (r_en[0] & w_empty) | (r_en[1] & r_ovf);

  // Storage needs no reset: level 0 hides whatever it holds.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= writedata[8:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_en    <= 2'b00;
      r_sent  <= '0;
    end else begin
      // Flush overrides any pop on the same edge; the pop is still counted below.
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
        if (w_push && !w_pop) begin
          r_level <= r_level + 1'b1;
        end else if (!w_push && w_pop) begin
          r_level <= r_level - 1'b1;
        end
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end

      if (w_wr && (address == 2'd2)) begin
        r_en <= writedata[1:0];
      end

      if (w_sent_clr) begin
        r_sent <= '0;
      end else if (w_pop) begin
        r_sent <= r_sent + 16'd1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd1: begin
        readdata[LW-1:0] = r_level;
        readdata[8]      = w_empty;
        readdata[9]      = w_full;
        readdata[10]     = r_ovf;
      end
      2'd2:    readdata[1:0]  = r_en;
      2'd3:    readdata[15:0] = r_sent;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_spw_tx_fifo_bridge.sv
module tb_spw_tx_fifo_bridge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        tx_write;
  logic        tx_flag;
  logic [7:0]  tx_data;
  logic        tx_rdy = 1'b0;
  logic        irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spw_tx_fifo_bridge #(
    .DEPTH(8),
    .LW   (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_write  (tx_write),
    .tx_flag   (tx_flag),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy),
    .irq       (irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #2;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL reset_tx_write: got %b want 0", tx_write);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq: got %b want 0", irq);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL reset_status: got %h want 00000100", d);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_irq_en: got %h want 00000000", d);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_sent: got %h want 00000000", d);
    end
  endtask

  task automatic test_basic_push();
    logic [31:0] d;
    tx_rdy = 1'b0;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL latency_before: tx_write %b want 0", tx_write);
    end
    bus_write(2'd0, 32'h041);
    checks++;
    if (tx_write !== 1'b1) begin
      errors++; $display("FAIL latency_after: tx_write %b want 1", tx_write);
    end
    bus_write(2'd0, 32'h1FF);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h002) begin
      errors++; $display("FAIL basic_status: got %h want 00000002", d);
    end
    checks++;
    if ({tx_write, tx_flag, tx_data} !== {1'b1, 1'b0, 8'h41}) begin
      errors++;
      $display("FAIL basic_head: got w=%b f=%b d=%h want w=1 f=0 d=41", tx_write, tx_flag, tx_data);
    end
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL data_reg_read: got %h want 00000000", d);
    end
    tx_rdy = 1'b1;
    step();
    checks++;
    if ({tx_write, tx_flag, tx_data} !== {1'b1, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL basic_second: got w=%b f=%b d=%h want w=1 f=1 d=ff", tx_write, tx_flag, tx_data);
    end
    step();
    tx_rdy = 1'b0;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL basic_drained: tx_write %b want 0", tx_write);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    tx_rdy = 1'b0;
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h010 + i);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h608) begin
      errors++; $display("FAIL ovf_status: got %h want 00000608", d);
    end
    tx_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({tx_write, tx_flag, tx_data} !== {1'b1, 9'h010 + 9'(i)}) begin
        errors++;
        $display("FAIL ovf_drain%0d: got w=%b fd=%h want w=1 fd=%h", i, tx_write,
                 {tx_flag, tx_data}, 9'h010 + 9'(i));
      end
      step();
    end
    tx_rdy = 1'b0;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL ovf_ninth_absent: tx_write %b want 0", tx_write);
    end
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h500) begin
      errors++; $display("FAIL ovf_sticky: got %h want 00000500", d);
    end
    bus_write(2'd1, 32'h1);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL ovf_clear: got %h want 00000100", d);
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    tx_rdy = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h120 + i);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h208) begin
      errors++; $display("FAIL full_status: got %h want 00000208", d);
    end
    tx_rdy = 1'b1;
    bus_write(2'd0, 32'h0AA);
    tx_rdy = 1'b0;
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h208) begin
      errors++; $display("FAIL full_pushpop_status: got %h want 00000208", d);
    end
    tx_rdy = 1'b1;
    for (int i = 1; i < 9; i++) begin
      checks++;
      if ({tx_flag, tx_data} !== ((i == 8) ? 9'h0AA : 9'h120 + 9'(i))) begin
        errors++;
        $display("FAIL full_drain%0d: got %h want %h", i, {tx_flag, tx_data},
                 (i == 8) ? 9'h0AA : 9'h120 + 9'(i));
      end
      step();
    end
    tx_rdy = 1'b0;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL full_drained: tx_write %b want 0", tx_write);
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    tx_rdy = 1'b0;
    bus_write(2'd2, 32'hFFFF_FFFD);
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL irq_en_read: got %h want 00000001", d);
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_empty: got %b want 1", irq);
    end
    bus_write(2'd0, 32'h077);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_after_push: got %b want 0", irq);
    end
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_after_pop: got %b want 1", irq);
    end
    bus_write(2'd2, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_ovf_idle: got %b want 0", irq);
    end
    for (int i = 0; i < 9; i++) bus_write(2'd0, 32'h030 + i);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_ovf_set: got %b want 1", irq);
    end
    bus_write(2'd1, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_ovf_clr: got %b want 0", irq);
    end
    bus_write(2'd1, 32'h2);
    bus_write(2'd2, 32'h0);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL flush_status: got %h want 00000100", d);
    end
  endtask

  task automatic test_flush_pop();
    logic [31:0] d;
    bus_write(2'd3, 32'h0);
    tx_rdy = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(2'd0, 32'h040 + i);
    tx_rdy = 1'b1;
    bus_write(2'd1, 32'h2);
    tx_rdy = 1'b0;
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL flushpop_status: got %h want 00000100", d);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL flushpop_sent: got %h want 00000001", d);
    end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] d;
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cnt_clear: got %h want 00000000", d);
    end
    // One push per edge while the codec streams: 65535 entries in, 65535 out.
    address    = 2'd0;
    writedata  = 32'h055;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tx_rdy     = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    step();
    tx_rdy = 1'b0;
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL cnt_stream_empty: tx_write %b want 0", tx_write);
    end
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'hFFFF) begin
      errors++; $display("FAIL cnt_ffff: got %h want 0000ffff", d);
    end
    bus_write(2'd0, 32'h066);
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cnt_wrap: got %h want 00000000", d);
    end
    bus_write(2'd0, 32'h067);
    tx_rdy = 1'b1;
    step();
    tx_rdy = 1'b0;
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL cnt_one: got %h want 00000001", d);
    end
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cnt_wr_clear: got %h want 00000000", d);
    end
    bus_write(2'd0, 32'h068);
    tx_rdy = 1'b1;
    bus_write(2'd3, 32'h0);
    tx_rdy = 1'b0;
    bus_read(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL cnt_clear_with_pop: got %h want 00000000", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    tx_rdy = 1'b0;
    bus_write(2'd2, 32'h1);
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h150 + i);
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h005) begin
      errors++; $display("FAIL mid_status: got %h want 00000005", d);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({tx_write, irq} !== 2'b00) begin
      errors++; $display("FAIL mid_in_reset: tx_write=%b irq=%b want 0 0", tx_write, irq);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    bus_read(2'd1, d);
    checks++;
    if (d !== 32'h100) begin
      errors++; $display("FAIL mid_status_after: got %h want 00000100", d);
    end
    bus_read(2'd2, d);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL mid_en_after: got %h want 00000000", d);
    end
    tx_rdy = 1'b1;
    step(); step(); step();
    checks++;
    if (tx_write !== 1'b0) begin
      errors++; $display("FAIL mid_no_stale: tx_write %b want 0", tx_write);
    end
    tx_rdy = 1'b0;
    bus_write(2'd0, 32'h0C3);
    checks++;
    if ({tx_write, tx_flag, tx_data} !== {1'b1, 1'b0, 8'hC3}) begin
      errors++;
      $display("FAIL mid_fresh_push: got w=%b f=%b d=%h want w=1 f=0 d=c3", tx_write, tx_flag, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_basic_push();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_flush_pop();
    test_counter_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
